// File: rtl/fifo_ser_pkg.sv
// Shared types and helpers for the FIFO-fed serial transmitter.
package fifo_ser_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } ser_state_t;

  // Clock cycles from the first start-bit cycle to the last stop-bit cycle.
  function automatic int unsigned frame_cycles(input int unsigned width,
                                               input int unsigned clks_per_bit,
                                               input int unsigned parity_en);
    return (32'd2 + width + parity_en) * clks_per_bit;
  endfunction

endpackage

// File: rtl/fifo_ser_tx_baud_tick.sv
// Bit-period timer: tick marks the last cycle of each bit, clr re-phases it to a frame start.
module baud_tick #(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic res_n,
  input  logic clr,
  output logic tick,
  output logic pre_tick_c
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] PRE_CNT  = CW'(CLKS_PER_BIT - 2);

  logic [CW-1:0] cnt;

  // One cycle ahead of tick, so tick itself can be a flop.
  assign pre_tick_c = (cnt == PRE_CNT);

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (clr) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      cnt  <= (cnt == LAST_CNT) ? '0 : cnt + CW'(1);
      tick <= pre_tick_c;
    end
  end

endmodule

// File: rtl/fifo_ser_tx.sv
// Drains the upstream FIFO into async serial frames: start, data LSB first, optional even parity, stop.
module fifo_ser_tx
  import fifo_ser_pkg::*;
#(
  parameter int unsigned WIDTH        = 4,
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned PARITY_EN    = 1
) (
  input  logic             clk,
  input  logic             res_n,
  input  logic [WIDTH-1:0] rdata,
  input  logic             empty,
  output logic             shift_out,
  input  logic             en,
  output logic             txd,
  output logic             busy,
  output logic             frame_done
);

  localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  ser_state_t       state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d, shifted;
  logic [IW-1:0]    idx_q, idx_d;
  logic             par_q, par_d;
  logic             txd_d, busy_d, frame_done_d;
  logic             tick, pre_tick_c;

  // Pop only between frames; gated by reset so the FIFO is never touched in reset.
  assign shift_out = res_n & en & ~empty &
                     ((state_q == IDLE) | ((state_q == STOP) & tick));

  baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_tick (
    .clk       (clk),
    .res_n     (res_n),
    .clr       (shift_out),
    .tick      (tick),
    .pre_tick_c(pre_tick_c)
  );

  // Next-state and next-output decode; txd is produced one cycle ahead of the line.
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    idx_d        = idx_q;
    par_d        = par_q;
    txd_d        = txd;
    shifted      = shift_q >> 1;
    frame_done_d = (state_q == STOP) && pre_tick_c;

    if (shift_out) begin
      state_d = START;
      shift_d = rdata;
      idx_d   = '0;
      par_d   = (PARITY_EN != 0) ? ^rdata : 1'b0;
      txd_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: txd_d = 1'b1;
        START: if (tick) begin
          state_d = DATA;
          txd_d   = shift_q[0];
        end
        DATA: if (tick) begin
          if (idx_q == LAST_IDX) begin
            if (PARITY_EN != 0) begin
              state_d = PARITY;
              txd_d   = par_q;
            end else begin
              state_d = STOP;
              txd_d   = 1'b1;
            end
          end else begin
            idx_d   = idx_q + IW'(1);
            shift_d = shifted;
            txd_d   = shifted[0];
          end
        end
        PARITY: if (tick) begin
          state_d = STOP;
          txd_d   = 1'b1;
        end
        STOP: if (tick) begin
          state_d = IDLE;
          txd_d   = 1'b1;
        end
        default: begin
          state_d = IDLE;
          txd_d   = 1'b1;
        end
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      idx_q      <= '0;
      par_q      <= 1'b0;
      txd        <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      idx_q      <= idx_d;
      par_q      <= par_d;
      txd        <= txd_d;
      busy       <= busy_d;
      frame_done <= frame_done_d;
    end
  end

endmodule

// File: tb/tb_fifo_ser_tx.sv
// Directed bench for fifo_ser_tx: FIFO model, per-cycle frame scoreboard, parity-less variant.
module tb_fifo_ser_tx;
  import fifo_ser_pkg::*;

  localparam int unsigned W   = 4;
  localparam int unsigned CPB = 4;
  localparam int unsigned F1  = frame_cycles(W, CPB, 1);
  localparam int unsigned F0  = frame_cycles(W, CPB, 0);

  typedef struct packed {
    logic txd;
    logic fd;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         res_n, en, empty, shift_out, txd, busy, frame_done;
  logic [W-1:0] rdata;
  logic         en0, empty0, shift_out0, txd0, busy0, frame_done0;
  logic [W-1:0] rdata0;

  exp_t exp_q[$];
  exp_t exp0_q[$];
  int   vec_cnt = 0;
  int   err_cnt = 0;
  int   pops = 0;
  int   busy_cycles = 0;

  logic [W-1:0] fmem [0:7];
  int           fcnt = 0;
  logic         push_v = 1'b0;
  logic         flush_v = 1'b0;
  logic [W-1:0] push_d = '0;
  logic         load0 = 1'b0;
  logic         have0 = 1'b0;

  assign rdata  = (fcnt == 0) ? '0 : fmem[0];
  assign empty  = (fcnt == 0);
  assign empty0 = ~have0;

  fifo_ser_tx #(.WIDTH(W), .CLKS_PER_BIT(CPB), .PARITY_EN(1)) dut (
    .clk(clk), .res_n(res_n), .rdata(rdata), .empty(empty), .shift_out(shift_out),
    .en(en), .txd(txd), .busy(busy), .frame_done(frame_done)
  );

  fifo_ser_tx #(.WIDTH(W), .CLKS_PER_BIT(CPB), .PARITY_EN(0)) dut0 (
    .clk(clk), .res_n(res_n), .rdata(rdata0), .empty(empty0), .shift_out(shift_out0),
    .en(en0), .txd(txd0), .busy(busy0), .frame_done(frame_done0)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Register-FIFO model feeding the main DUT.
  always @(posedge clk) begin : fifo_model
    logic [W-1:0] m [0:7];
    int n;
    m = fmem;
    n = fcnt;
    if (shift_out && n > 0) begin
      for (int i = 0; i < 7; i++) m[i] = m[i+1];
      n--;
      pops <= pops + 1;
    end
    if (push_v && n < 8) begin
      m[n] = push_d;
      n++;
    end
    if (flush_v) n = 0;
    fmem <= m;
    fcnt <= n;
  end

  always @(posedge clk) begin : fifo0_model
    if (shift_out0) have0 <= 1'b0;
    else if (load0) have0 <= 1'b1;
  end

  // Scoreboard monitor: every busy cycle consumes one expected line/done value.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (res_n) begin
      if (shift_out) check("pop_while_empty", 32'(empty), 32'd0);
      if (shift_out && busy) check("pop_with_done", 32'(frame_done), 32'd1);
      if (busy) begin
        busy_cycles <= busy_cycles + 1;
        if (exp_q.size() == 0) check("extra_busy", 32'(busy), 32'd0);
        else begin
          e = exp_q.pop_front();
          check("txd", 32'(txd), 32'(e.txd));
          check("frame_done", 32'(frame_done), 32'(e.fd));
        end
      end else begin
        check("idle_txd", 32'(txd), 32'd1);
        check("idle_done", 32'(frame_done), 32'd0);
      end
    end
  end

  task automatic push_word(input logic [W-1:0] w, input bit expect_tx);
    logic b [0:6];
    push_d = w;
    push_v = 1'b1;
    if (expect_tx) begin
      b[0] = 1'b0;
      for (int i = 0; i < 4; i++) b[i+1] = w[i];
      b[5] = ^w;
      b[6] = 1'b1;
      for (int k = 0; k < 7; k++)
        for (int c = 0; c < int'(CPB); c++)
          exp_q.push_back('{txd: b[k], fd: (k == 6 && c == int'(CPB) - 1)});
    end
    @(posedge clk);
    #1 push_v = 1'b0;
  endtask

  task automatic wait_pop(input string tag);
    int start;
    start = pops;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (pops != start) break;
    end
    check(tag, 32'(pops - start), 32'd1);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 200; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    check({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    check({tag, "_busy_low"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int   p, bc0;
    bit   got;
    exp_t e;
    res_n = 1'b0;
    en    = 1'b0;
    en0   = 1'b1;
    rdata0 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_txd", 32'(txd), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(frame_done), 32'd0);
    check("rst_pop", 32'(shift_out), 32'd0);
    res_n = 1'b1;
    @(posedge clk);
    #1;

    // Single word 4'b1011.
    en = 1'b1;
    bc0 = busy_cycles;
    push_word(4'b1011, 1'b1);
    wait_pop("single_pop");
    drain("single");
    check("single_len", 32'(busy_cycles - bc0), 32'(F1));
    check("single_pops", 32'(pops), 32'd1);

    // Back-to-back 4'h3, 4'hC.
    bc0 = busy_cycles;
    p = pops;
    push_word(4'h3, 1'b1);
    push_word(4'hC, 1'b1);
    drain("b2b");
    check("b2b_len", 32'(busy_cycles - bc0), 32'(2 * F1));
    check("b2b_pops", 32'(pops - p), 32'd2);

    // Enable gating.
    en = 1'b0;
    push_word(4'h5, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("gate_nopop", 32'(shift_out), 32'd0);
      check("gate_txd", 32'(txd), 32'd1);
    end
    @(posedge clk);
    #1 en = 1'b1;
    @(negedge clk);
    check("pop_on_en", 32'(shift_out), 32'd1);
    wait_pop("en_pop");
    repeat (4) @(posedge clk);
    #1 en = 1'b0;
    push_word(4'hA, 1'b0);
    drain("gate");
    p = pops;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("gate_hold", 32'(shift_out), 32'd0);
    end
    check("gate_pops", 32'(pops - p), 32'd0);
    check("gate_fcnt", 32'(fcnt), 32'd1);
    flush_v = 1'b1;
    @(posedge clk);
    #1 flush_v = 1'b0;

    // Empty FIFO with enable high.
    en = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check("empty_pop", 32'(shift_out), 32'd0);
      check("empty_busy", 32'(busy), 32'd0);
      check("empty_txd", 32'(txd), 32'd1);
    end

    // Reset during DATA bit 2.
    @(posedge clk);
    #1;
    push_word(4'h6, 1'b1);
    wait_pop("rst_frame_pop");
    repeat (14) @(posedge clk);
    #1;
    res_n = 1'b0;
    exp_q.delete();
    #1;
    check("midrst_txd", 32'(txd), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_pop", 32'(shift_out), 32'd0);
    p = pops;
    push_word(4'h9, 1'b1);
    @(posedge clk);
    #1 res_n = 1'b1;
    wait_pop("post_rst_pop");
    drain("post_rst");
    check("post_rst_pops", 32'(pops - p), 32'd1);

    // Parity-less instance, word 4'hF.
    rdata0 = 4'hF;
    load0  = 1'b1;
    @(posedge clk);
    #1 load0 = 1'b0;
    for (int k = 0; k < 6; k++)
      for (int c = 0; c < int'(CPB); c++)
        exp0_q.push_back('{txd: (k != 0), fd: (k == 5 && c == int'(CPB) - 1)});
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (shift_out0) got = 1'b1;
    end
    check("p0_pop", 32'(got), 32'd1);
    for (int i = 0; i < int'(F0); i++) begin
      @(negedge clk);
      e = exp0_q.pop_front();
      check("p0_txd", 32'(txd0), 32'(e.txd));
      check("p0_done", 32'(frame_done0), 32'(e.fd));
      check("p0_busy", 32'(busy0), 32'd1);
    end
    @(negedge clk);
    check("p0_busy_low", 32'(busy0), 32'd0);
    check("p0_idle_txd", 32'(txd0), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
